mmio_periph_responder: RTL and testbench

//   Responder side of the CPU data-memory load/store bus for the peripheral window.
//   It decodes word accesses from the pipeline's MEM stage and serves a 32-bit

---
 rtl/mmio_periph_responder_pkg.sv | 24 ++
 rtl/mmio_timer.sv | 54 +++++
 rtl/mmio_periph_responder.sv | 92 +++++++++
 tb/tb_mmio_periph_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_periph_responder_pkg.sv
// Shared constants for the peripheral MMIO window: base address, register
// offsets inside the 32-byte window and TCON bit positions.
package mmio_periph_responder_pkg;

  localparam logic [31:0] BASE_ADDR_DEFAULT  = 32'h4000_0000;
  localparam logic [11:0] DIGI_RESET_DEFAULT = 12'hFFF;

  localparam logic [4:0] OFF_TH      = 5'h00;
  localparam logic [4:0] OFF_TL      = 5'h04;
  localparam logic [4:0] OFF_TCON    = 5'h08;
  localparam logic [4:0] OFF_LED     = 5'h0C;
  localparam logic [4:0] OFF_DIGI    = 5'h10;
  localparam logic [4:0] OFF_SYSTICK = 5'h14;

  localparam int TCON_EN  = 0;
  localparam int TCON_IE  = 1;
  localparam int TCON_IRQ = 2;

  // Word-aligned byte offset within the window; the byte lane bits are ignored.
  function automatic logic [4:0] word_off(input logic [2:0] word_idx);
    return {word_idx, 2'b00};
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// Reload timer: TH holds the reload value, TL counts up while enabled and
// reloads from TH on overflow, optionally latching a sticky irq flag in TCON.
module mmio_timer
  import mmio_periph_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        th_we,
  input  logic        tl_we,
  input  logic        tcon_we,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon
);

  logic [31:0] th_reg;
  logic [31:0] tl_reg;
  logic [2:0]  tcon_reg;
  logic        overflow;

  // A CPU store to TL preempts that cycle's counting step, so no overflow
  // (and no irq) is generated from the value being overwritten.
  assign overflow = tcon_reg[TCON_EN] && (tl_reg == 32'hFFFF_FFFF) && !tl_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      th_reg   <= 32'h0;
      tl_reg   <= 32'h0;
      tcon_reg <= 3'b000;
    end else begin
      if (th_we) begin
        th_reg <= wdata;
      end

      if (tl_we) begin
        tl_reg <= wdata;
      end else if (tcon_reg[TCON_EN]) begin
        tl_reg <= overflow ? th_reg : tl_reg + 32'd1;
      end

      if (tcon_we) begin
        tcon_reg <= wdata[2:0];
      end else if (overflow && tcon_reg[TCON_IE]) begin
        tcon_reg[TCON_IRQ] <= 1'b1;
      end
    end
  end

  assign th   = th_reg;
  assign tl   = tl_reg;
  assign tcon = tcon_reg;

endmodule

// File: rtl/mmio_periph_responder.sv
// Peripheral window responder on the data-memory bus: address decode, LED,
// 7-segment and systick registers, the reload timer and a zero-latency read mux.
module mmio_periph_responder
  import mmio_periph_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEFAULT,
  parameter logic [11:0] DIGI_RESET = DIGI_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic [7:0]  leds,
  output logic [3:0]  AN,
  output logic [7:0]  BCD,
  output logic        irq
);

  logic        hit;
  logic [4:0]  off;
  logic        wr_en;
  logic        rd_en;
  logic        unused_addr_bits;

  logic [7:0]  leds_reg;
  logic [11:0] digi_reg;
  logic [31:0] systick_reg;
  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [31:0] rd_data;

  assign hit              = (addr[31:5] == BASE_ADDR[31:5]);
  assign off              = word_off(addr[4:2]);
  assign wr_en            = MemWrite && hit;
  assign rd_en            = MemRead && hit;
  assign unused_addr_bits = ^addr[1:0];

  mmio_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .th_we   (wr_en && (off == OFF_TH)),
    .tl_we   (wr_en && (off == OFF_TL)),
    .tcon_we (wr_en && (off == OFF_TCON)),
    .wdata   (WriteData),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon)
  );

  // SYSTICK has no write path: it is a pure cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      leds_reg    <= 8'h00;
      digi_reg    <= DIGI_RESET;
      systick_reg <= 32'h0;
    end else begin
      systick_reg <= systick_reg + 32'd1;
      if (wr_en && (off == OFF_LED)) begin
        leds_reg <= WriteData[7:0];
      end
      if (wr_en && (off == OFF_DIGI)) begin
        digi_reg <= WriteData[11:0];
      end
    end
  end

  always_comb begin
    rd_data = 32'h0;
    if (rd_en) begin
      case (off)
        OFF_TH:      rd_data = th;
        OFF_TL:      rd_data = tl;
        OFF_TCON:    rd_data = {29'h0, tcon};
        OFF_LED:     rd_data = {24'h0, leds_reg};
        OFF_DIGI:    rd_data = {20'h0, digi_reg};
        OFF_SYSTICK: rd_data = systick_reg;
        default:     rd_data = 32'h0;
      endcase
    end
  end

  assign ReadData = rd_data;
  assign leds     = leds_reg;
  assign AN       = digi_reg[11:8];
  assign BCD      = digi_reg[7:0];
  assign irq      = tcon[TCON_IRQ];

endmodule

// File: tb/tb_mmio_periph_responder.sv
// Self-checking bench for the peripheral MMIO responder: register table,
// timer reload/irq sequences, systick, write/count conflict and mid-run reset.
module tb_mmio_periph_responder;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] ReadData;
  logic [7:0]  leds;
  logic [3:0]  AN;
  logic [7:0]  BCD;
  logic        irq;

  mmio_periph_responder dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .WriteData (WriteData),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .ReadData  (ReadData),
    .leds      (leds),
    .AN        (AN),
    .BCD       (BCD),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  off;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vecs[8];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb_q[$];
  string       sb_name[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
    addr      = a;
    WriteData = d;
    MemWrite  = 1'b1;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
    WriteData = 32'h0;
    addr      = 32'h0;
  endtask

  // Expected value is queued when the load is issued, popped when ReadData is sampled.
  task automatic read_expect(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] e;
    string       nm;
    sb_q.push_back(exp);
    sb_name.push_back(name);
    addr    = a;
    MemRead = 1'b1;
    #1;
    e  = sb_q.pop_front();
    nm = sb_name.pop_front();
    check(nm, ReadData, e);
    MemRead = 1'b0;
  endtask

  task automatic read_value(input logic [31:0] a, output logic [31:0] v);
    addr    = a;
    MemRead = 1'b1;
    #1;
    v       = ReadData;
    MemRead = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] s0, s1;

    vecs[0] = '{5'h0C, 32'hABCD_1234, 32'h0000_0034};
    vecs[1] = '{5'h10, 32'h0000_0E3F, 32'h0000_0E3F};
    vecs[2] = '{5'h00, 32'h1234_5678, 32'h1234_5678};
    vecs[3] = '{5'h08, 32'hFFFF_FFF4, 32'h0000_0004};
    vecs[4] = '{5'h08, 32'h0000_0000, 32'h0000_0000};
    vecs[5] = '{5'h18, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[6] = '{5'h1C, 32'h0000_0001, 32'h0000_0000};
    vecs[7] = '{5'h04, 32'h0000_0100, 32'h0000_0100};

    reset = 1'b1; addr = 32'h0; WriteData = 32'h0; MemRead = 1'b0; MemWrite = 1'b0;
    tick(2);
    reset = 1'b0;

    // Reset state
    check("rst_an", {28'h0, AN}, 32'hF);
    check("rst_bcd", {24'h0, BCD}, 32'hFF);
    check("rst_leds", {24'h0, leds}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    addr = BASE + 32'h10;
    #1;
    check("rst_noread", ReadData, 32'h0);
    read_expect("rst_digi", BASE + 32'h10, 32'h0000_0FFF);
    read_expect("rst_tcon", BASE + 32'h08, 32'h0);
    read_expect("rst_tl", BASE + 32'h04, 32'h0);

    // Register write/readback table
    for (int i = 0; i < 8; i++) begin
      write_reg(BASE + {27'h0, vecs[i].off}, vecs[i].wdata);
      read_expect($sformatf("vec%0d_rd", i), BASE + {27'h0, vecs[i].off}, vecs[i].exp_rd);
    end
    check("leds_pin", {24'h0, leds}, 32'h34);
    check("an_pin", {28'h0, AN}, 32'hE);
    check("bcd_pin", {24'h0, BCD}, 32'h3F);
    check("irq_after_clear", {31'h0, irq}, 32'h0);

    // Reload timer with irq
    write_reg(BASE + 32'h00, 32'hFFFF_FFFC);
    write_reg(BASE + 32'h04, 32'hFFFF_FFFE);
    write_reg(BASE + 32'h08, 32'h3);
    read_expect("t2_tl0", BASE + 32'h04, 32'hFFFF_FFFE);
    tick(1);
    read_expect("t2_tl1", BASE + 32'h04, 32'hFFFF_FFFF);
    check("t2_irq_pre", {31'h0, irq}, 32'h0);
    tick(1);
    read_expect("t2_tl_reload", BASE + 32'h04, 32'hFFFF_FFFC);
    check("t2_irq_rise", {31'h0, irq}, 32'h1);
    tick(1);
    read_expect("t2_tl_next", BASE + 32'h04, 32'hFFFF_FFFD);
    check("t2_irq_sticky", {31'h0, irq}, 32'h1);
    write_reg(BASE + 32'h08, 32'h3);
    check("t2_irq_clear", {31'h0, irq}, 32'h0);
    read_expect("t2_tcon", BASE + 32'h08, 32'h3);
    write_reg(BASE + 32'h08, 32'h0);

    // Simultaneous read and write returns the pre-write value
    addr = BASE + 32'h0C; WriteData = 32'h77; MemRead = 1'b1; MemWrite = 1'b1;
    #1;
    check("rw_prewrite", ReadData, 32'h34);
    @(posedge clk);
    #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    read_expect("rw_postwrite", BASE + 32'h0C, 32'h77);

    // Systick
    read_value(BASE + 32'h14, s0);
    tick(7);
    read_value(BASE + 32'h14, s1);
    check("systick_delta", s1 - s0, 32'd7);
    read_value(BASE + 32'h14, s0);
    write_reg(BASE + 32'h14, 32'h0);
    read_expect("systick_wr_ignored", BASE + 32'h14, s0 + 32'd1);

    // Store to TL on the overflow cycle wins and suppresses the irq
    write_reg(BASE + 32'h00, 32'h0);
    write_reg(BASE + 32'h04, 32'hFFFF_FFFD);
    write_reg(BASE + 32'h08, 32'h3);
    tick(2);
    read_expect("t5_tl_max", BASE + 32'h04, 32'hFFFF_FFFF);
    write_reg(BASE + 32'h04, 32'h5);
    read_expect("t5_tl_written", BASE + 32'h04, 32'h5);
    check("t5_irq", {31'h0, irq}, 32'h0);
    tick(1);
    read_expect("t5_tl_resume", BASE + 32'h04, 32'h6);
    write_reg(BASE + 32'h08, 32'h0);

    // TH = all ones: overflow every cycle
    write_reg(BASE + 32'h00, 32'hFFFF_FFFF);
    write_reg(BASE + 32'h04, 32'hFFFF_FFFF);
    write_reg(BASE + 32'h08, 32'h1);
    for (int i = 0; i < 3; i++) begin
      read_expect($sformatf("thmax_tl%0d", i), BASE + 32'h04, 32'hFFFF_FFFF);
      tick(1);
    end
    write_reg(BASE + 32'h08, 32'h0);

    // Reset mid-count with a store to LED in the same cycle
    write_reg(BASE + 32'h0C, 32'h55);
    write_reg(BASE + 32'h10, 32'h123);
    write_reg(BASE + 32'h08, 32'h3);
    tick(3);
    addr = BASE + 32'h0C; WriteData = 32'hAA; MemWrite = 1'b1; reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; MemWrite = 1'b0; WriteData = 32'h0;
    check("t6_leds", {24'h0, leds}, 32'h0);
    check("t6_an", {28'h0, AN}, 32'hF);
    check("t6_bcd", {24'h0, BCD}, 32'hFF);
    check("t6_irq", {31'h0, irq}, 32'h0);
    read_expect("t6_systick", BASE + 32'h14, 32'h0);
    read_expect("t6_tcon", BASE + 32'h08, 32'h0);
    read_expect("t6_tl", BASE + 32'h04, 32'h0);
    tick(2);
    read_expect("t6_tl_idle", BASE + 32'h04, 32'h0);
    read_expect("t6_th", BASE + 32'h00, 32'h0);
    read_expect("t6_unused18", BASE + 32'h18, 32'h0);
    read_expect("t6_miss", 32'h1000_0000, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
